// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg: shared constants and types for the RISC-V fetch front end.
//   DEF_XLEN      : default datapath / address width
//   DEF_RESET_VEC : default PC value taken on reset
//   INSTR_BYTES   : size of one (uncompressed) instruction in bytes
//   npc_sel_e     : which source feeds the next PC on a given edge
// ---------------------------------------------------------------------------
package rv_pkg;

  localparam int          DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam int          INSTR_BYTES   = 4;

  // Listed in priority order, highest first.
  typedef enum logic [2:0] {
    NPC_TRAP  = 3'd0,
    NPC_HOLD  = 3'd1,
    NPC_REDIR = 3'd2,
    NPC_RAS   = 3'd3,
    NPC_SEQ   = 3'd4
  } npc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// ---------------------------------------------------------------------------
// pc_ras: circular return-address stack.
//   clk          in  : clock, rising edge
//   clr          in  : asynchronous active-high reset (pointer/count only)
//   push_i       in  : push push_data_i
//   pop_i        in  : pop the top entry; caller only asserts it when
//                      count_o != 0
//   push_data_i  in  : value to push
//   top_o        out : current top-of-stack entry (meaningless when empty)
//   count_o      out : number of valid entries, saturates at RAS_DEPTH
// push_i and pop_i together replace the top entry in place.
// ---------------------------------------------------------------------------
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4,
  parameter int RAS_AW    = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [XLEN-1:0]   push_data_i,
  output logic [XLEN-1:0]   top_o,
  output logic [RAS_AW:0]   count_o
);

  // Entry storage carries no reset: contents are don't-care until pushed.
  logic [XLEN-1:0] mem_q [RAS_DEPTH];

  // ptr_q points at the next free slot; the top lives at ptr_q - 1.
  logic [RAS_AW-1:0] ptr_q, ptr_d;
  logic [RAS_AW:0]   count_q, count_d;
  logic [RAS_AW-1:0] top_idx;
  logic [RAS_AW-1:0] wr_idx;
  logic              wr_en;

  assign top_idx = ptr_q - RAS_AW'(1);

  always_comb begin
    ptr_d   = ptr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = ptr_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        // When full, the write lands on the oldest entry because the
        // pointer has wrapped round to it; count just saturates.
        wr_en  = 1'b1;
        wr_idx = ptr_q;
        ptr_d  = ptr_q + RAS_AW'(1);
        if (count_q != (RAS_AW+1)'(RAS_DEPTH)) begin
          count_d = count_q + (RAS_AW+1)'(1);
        end
      end
      2'b01: begin
        ptr_d   = top_idx;
        count_d = count_q - (RAS_AW+1)'(1);
      end
      2'b11: begin
        wr_en  = 1'b1;
        wr_idx = top_idx;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= push_data_i;
    end
  end

  assign top_o   = mem_q[top_idx];
  assign count_o = count_q;

endmodule

// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit: program counter for the fetch stage.
//   clk            in  : clock, rising edge
//   clr            in  : asynchronous active-high reset
//   stall          in  : hold PC and RAS
//   trap_en        in  : take trap (highest priority, overrides stall)
//   trap_vec       in  : trap handler address
//   redir_en       in  : branch/jump taken
//   redir_tgt      in  : branch/jump target
//   call_en        in  : current fetch is a call, push pc_plus
//   ret_en         in  : current fetch is a return, pop RAS into pc
//   pc             out : current fetch address (registered)
//   pc_plus        out : pc + INC (combinational, wraps silently)
//   ras_count      out : valid RAS entries
//   misalign       out : one-cycle pulse, last loaded target had [1:0] != 0
//   ras_underflow  out : one-cycle pulse, return seen with an empty RAS
// ---------------------------------------------------------------------------
module pc_unit
  import rv_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter int              INC       = INSTR_BYTES,
  parameter int              RAS_DEPTH = 4,
  parameter int              RAS_AW    = $clog2(RAS_DEPTH)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              stall,
  input  logic              trap_en,
  input  logic [XLEN-1:0]   trap_vec,
  input  logic              redir_en,
  input  logic [XLEN-1:0]   redir_tgt,
  input  logic              call_en,
  input  logic              ret_en,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus,
  output logic [RAS_AW:0]   ras_count,
  output logic              misalign,
  output logic              ras_underflow
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic            ras_underflow_q, ras_underflow_d;
  npc_sel_e        npc_sel;

  logic [XLEN-1:0] ras_top;
  logic [RAS_AW:0] ras_cnt;
  logic            ras_empty;
  logic            ctl_live;   // call/ret may act this cycle
  logic            ras_push;
  logic            ras_pop;

  assign pc_plus   = pc_q + XLEN'(INC);
  assign ras_empty = (ras_cnt == '0);

  // Trap and stall both freeze the RAS; otherwise call/ret act even when a
  // redirect owns the PC (JAL/JALR push, a return resolved in EX pops).
  assign ctl_live = !trap_en && !stall;
  assign ras_push = ctl_live && call_en;
  assign ras_pop  = ctl_live && ret_en && !ras_empty;

  always_comb begin
    npc_sel = NPC_SEQ;
    if (trap_en) begin
      npc_sel = NPC_TRAP;
    end else if (stall) begin
      npc_sel = NPC_HOLD;
    end else if (redir_en) begin
      npc_sel = NPC_REDIR;
    end else if (ret_en && !ras_empty) begin
      npc_sel = NPC_RAS;
    end
  end

  always_comb begin
    pc_d            = pc_plus;
    misalign_d      = 1'b0;
    ras_underflow_d = ctl_live && ret_en && ras_empty;
    unique case (npc_sel)
      NPC_TRAP: begin
        pc_d       = {trap_vec[XLEN-1:2], 2'b00};
        misalign_d = (trap_vec[1:0] != 2'b00);
      end
      NPC_HOLD:  pc_d = pc_q;
      NPC_REDIR: begin
        pc_d       = {redir_tgt[XLEN-1:2], 2'b00};
        misalign_d = (redir_tgt[1:0] != 2'b00);
      end
      NPC_RAS:   pc_d = ras_top;
      NPC_SEQ:   pc_d = pc_plus;
      default:   pc_d = pc_plus;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q            <= RESET_VEC;
      misalign_q      <= 1'b0;
      ras_underflow_q <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      misalign_q      <= misalign_d;
      ras_underflow_q <= ras_underflow_d;
    end
  end

  // pc_plus is always INC-aligned given an aligned pc, so RAS entries
  // never need masking.
  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH),
    .RAS_AW    (RAS_AW)
  ) u_ras (
    .clk         (clk),
    .clr         (clr),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (pc_plus),
    .top_o       (ras_top),
    .count_o     (ras_cnt)
  );

  assign pc            = pc_q;
  assign ras_count     = ras_cnt;
  assign misalign      = misalign_q;
  assign ras_underflow = ras_underflow_q;

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

  localparam int XLEN = 32;

  logic            clk;
  logic            clr;
  logic            stall;
  logic            trap_en;
  logic [XLEN-1:0] trap_vec;
  logic            redir_en;
  logic [XLEN-1:0] redir_tgt;
  logic            call_en;
  logic            ret_en;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus;
  logic [2:0]      ras_count;
  logic            misalign;
  logic            ras_underflow;

  int vectors;
  int miscompares;

  pc_unit dut (
    .clk           (clk),
    .clr           (clr),
    .stall         (stall),
    .trap_en       (trap_en),
    .trap_vec      (trap_vec),
    .redir_en      (redir_en),
    .redir_tgt     (redir_tgt),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .pc            (pc),
    .pc_plus       (pc_plus),
    .ras_count     (ras_count),
    .misalign      (misalign),
    .ras_underflow (ras_underflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall     = 1'b0;
    trap_en   = 1'b0;
    trap_vec  = '0;
    redir_en  = 1'b0;
    redir_tgt = '0;
    call_en   = 1'b0;
    ret_en    = 1'b0;
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pc(input string tag, input logic [XLEN-1:0] exp);
    check(tag, pc, exp);
  endtask

  task automatic check_cnt(input string tag, input int exp);
    check(tag, XLEN'(ras_count), XLEN'(exp));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // reset state
    check_pc ("rst_pc", 32'h0);
    check_cnt("rst_cnt", 0);
    check    ("rst_mis", XLEN'(misalign), 32'h0);
    check    ("rst_unf", XLEN'(ras_underflow), 32'h0);
    check    ("rst_pcplus", pc_plus, 32'h4);

    // sequential
    tick(); check_pc("seq1", 32'h4);
    tick(); check_pc("seq2", 32'h8);
    tick(); check_pc("seq3", 32'hC);

    // async reset mid-cycle, no clock edge involved
    #2 clr = 1'b1;
    #1 check_pc("async_clr", 32'h0);
    clr = 1'b0;

    // advance to 0x10
    tick(); tick(); tick(); tick();
    check_pc("to_0x10", 32'h10);

    // stall beats redirect
    stall = 1'b1; redir_en = 1'b1; redir_tgt = 32'h80;
    tick(); check_pc("stall1", 32'h10);
    tick(); check_pc("stall2", 32'h10);
    stall = 1'b0;
    tick(); check_pc("stall_rel", 32'h80);
    idle();

    // trap beats everything, RAS untouched
    trap_en = 1'b1; trap_vec = 32'h100; stall = 1'b1;
    redir_en = 1'b1; redir_tgt = 32'h200; call_en = 1'b1;
    tick(); check_pc("trap_pc", 32'h100);
    check_cnt("trap_cnt", 0);
    check("trap_mis", XLEN'(misalign), 32'h0);
    idle();

    // call with jump, then return
    redir_en = 1'b1; redir_tgt = 32'h20;
    tick(); check_pc("goto_20", 32'h20);
    call_en = 1'b1; redir_tgt = 32'h200;
    tick(); check_pc("call_pc", 32'h200);
    check_cnt("call_cnt", 1);
    idle();
    tick(); check_pc("seq_204", 32'h204);
    ret_en = 1'b1;
    tick(); check_pc("ret_pc", 32'h24);
    check_cnt("ret_cnt", 0);
    idle();

    // five calls into a depth-4 stack
    redir_en = 1'b1; redir_tgt = 32'h0;
    tick(); check_pc("goto_0", 32'h0);
    call_en = 1'b1;
    redir_tgt = 32'h10;   tick(); check_cnt("push1_cnt", 1);
    redir_tgt = 32'h20;   tick(); check_cnt("push2_cnt", 2);
    redir_tgt = 32'h30;   tick(); check_cnt("push3_cnt", 3);
    redir_tgt = 32'h40;   tick(); check_cnt("push4_cnt", 4);
    redir_tgt = 32'h1000; tick(); check_cnt("push5_cnt", 4);
    check_pc("push5_pc", 32'h1000);
    idle();
    ret_en = 1'b1;
    tick(); check_pc("pop1_pc", 32'h44); check_cnt("pop1_cnt", 3);
    tick(); check_pc("pop2_pc", 32'h34); check_cnt("pop2_cnt", 2);
    tick(); check_pc("pop3_pc", 32'h24); check_cnt("pop3_cnt", 1);
    tick(); check_pc("pop4_pc", 32'h14); check_cnt("pop4_cnt", 0);
    check("pop4_unf", XLEN'(ras_underflow), 32'h0);
    tick(); check_pc("pop5_pc", 32'h18);
    check("pop5_unf", XLEN'(ras_underflow), 32'h1);
    check_cnt("pop5_cnt", 0);
    idle();
    tick(); check_pc("after_unf_pc", 32'h1C);
    check("unf_clear", XLEN'(ras_underflow), 32'h0);

    // call+ret with a non-empty stack replaces the top
    redir_en = 1'b1; redir_tgt = 32'h300;
    tick();
    call_en = 1'b1; redir_tgt = 32'h400;
    tick(); check_pc("cr_call_pc", 32'h400); check_cnt("cr_call_cnt", 1);
    idle();
    call_en = 1'b1; ret_en = 1'b1;
    tick(); check_pc("cr_both_pc", 32'h304); check_cnt("cr_both_cnt", 1);
    idle();
    ret_en = 1'b1;
    tick(); check_pc("cr_ret_pc", 32'h404); check_cnt("cr_ret_cnt", 0);

    // call+ret with empty stack: underflow, push still happens
    call_en = 1'b1;
    tick(); check_pc("ce_pc", 32'h408); check_cnt("ce_cnt", 1);
    check("ce_unf", XLEN'(ras_underflow), 32'h1);
    idle();
    ret_en = 1'b1;
    tick(); check_pc("ce_ret_pc", 32'h408); check_cnt("ce_ret_cnt", 0);
    idle();

    // misaligned redirect, pulse cleared by stall
    redir_en = 1'b1; redir_tgt = 32'h103;
    tick(); check_pc("mis_pc", 32'h100);
    check("mis_set", XLEN'(misalign), 32'h1);
    idle(); stall = 1'b1;
    tick(); check_pc("mis_hold", 32'h100);
    check("mis_clr", XLEN'(misalign), 32'h0);
    idle();
    tick(); check_pc("mis_seq", 32'h104);

    // misaligned trap vector
    trap_en = 1'b1; trap_vec = 32'h202;
    tick(); check_pc("trapmis_pc", 32'h200);
    check("trapmis_set", XLEN'(misalign), 32'h1);
    idle();

    // wrap at top of address space
    redir_en = 1'b1; redir_tgt = 32'hFFFF_FFFC;
    tick(); check_pc("wrap_top", 32'hFFFF_FFFC);
    check("wrap_plus", pc_plus, 32'h0);
    idle();
    tick(); check_pc("wrap_zero", 32'h0);
    check("wrap_mis", XLEN'(misalign), 32'h0);

    // reset mid-redirect with controls still asserted
    redir_en = 1'b1; redir_tgt = 32'h500; call_en = 1'b1;
    #2 clr = 1'b1;
    #1 check_pc("clr_redir_pc", 32'h0);
    tick(); check_pc("clr_held_pc", 32'h0);
    check_cnt("clr_held_cnt", 0);
    idle();
    clr = 1'b0;
    tick(); check_pc("post_clr", 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
